// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared definitions for the dsp_mac_pipe MAC slice.
//   - ALU op encodings and the pre-subtract bit index
//   - chw_f(): channel-tag width derived from the channel count
//   - stage_tag_t: control tag that travels alongside the datapath
package dsp_mac_pkg;

    localparam logic [1:0] OP_ADD_C = 2'b00;  // r = m + c
    localparam logic [1:0] OP_C_SUB = 2'b01;  // r = c - m
    localparam logic [1:0] OP_ACC   = 2'b10;  // r = acc[ch] (or 0) + m
    localparam logic [1:0] OP_CASC  = 2'b11;  // r = pcin + m
    localparam int         PRE_SUB  = 2;      // op bit selecting a - d

    // Tag channel field is fixed-width so the struct is parameter-free;
    // the top checks that its channel tag fits.
    localparam int TAG_CHW = 16;

    typedef struct packed {
        logic               valid;
        logic [TAG_CHW-1:0] ch;
        logic [2:0]         op;
        logic               first;
    } stage_tag_t;

    function automatic int chw_f(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/dsp_mac_outfmt.sv
// dsp_mac_outfmt: combinational output formatter.
//   Arithmetic right shift by SHIFT, then reduce ACCW -> OW bits.
//   Build option DSP_MAC_SAT_EN: clamp to the OW-bit signed range and flag
//   sat_o; without it the low OW bits are taken (wrap) and sat_o is 0.
// Ports:
//   r_i   in  ACCW  signed full-width result
//   p_o   out OW    formatted result
//   sat_o out 1     p_o was clamped
module dsp_mac_outfmt #(
    parameter int ACCW  = 48,
    parameter int SHIFT = 0,
    parameter int OW    = 48
) (
    input  logic signed [ACCW-1:0] r_i,
    output logic signed [OW-1:0]   p_o,
    output logic                   sat_o
);

    logic signed [ACCW-1:0] shifted;
    assign shifted = r_i >>> SHIFT;

`ifdef DSP_MAC_SAT_EN
    // Value fits in OW bits iff every bit from OW-1 upward equals the sign.
    logic [ACCW-OW:0] hi;
    logic [OW-1:0]    pmin;
    assign hi = shifted[ACCW-1:OW-1];

    always_comb begin
        pmin         = '0;
        pmin[OW-1]   = 1'b1;
        sat_o        = !((&hi) || !(|hi));
        p_o          = shifted[OW-1:0];
        if (sat_o) begin
            p_o = shifted[ACCW-1] ? pmin : ~pmin;
        end
    end
`else
    logic unused_hi;
    assign p_o       = shifted[OW-1:0];
    assign sat_o     = 1'b0;
    assign unused_hi = ^shifted;
`endif

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage pre-add / multiply / ALU MAC with NCH interleaved
// accumulators and a cascade path. m = b*(a +/- d); p = m+c, c-m,
// acc[ch]+m or pcin+m. Latency 3 edges after acceptance, 1 sample/cycle.
// Optional build macro: DSP_MAC_SAT_EN (saturate p, drive out_sat).
// Ports:
//   clock, reset_n (async low), ce (global enable, 0 freezes everything)
//   in_valid/in_ch/in_op/in_first  sample control
//   a, d (AW), b (BW), c (ACCW)    operands, registered in S1
//   pcin (ACCW)                    cascade input, used in S4
//   out_valid/out_ch/p/pcout/out_sat  registered results
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter  int AW    = 25,
    parameter  int BW    = 18,
    parameter  int ACCW  = 48,
    parameter  int NCH   = 4,
    parameter  int SHIFT = 0,
    parameter  int OW    = 48,
    localparam int CHW   = chw_f(NCH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic [CHW-1:0]         in_ch,
    input  logic [2:0]             in_op,
    input  logic                   in_first,
    input  logic signed [AW-1:0]   a,
    input  logic signed [AW-1:0]   d,
    input  logic signed [BW-1:0]   b,
    input  logic signed [ACCW-1:0] c,
    input  logic signed [ACCW-1:0] pcin,
    output logic                   out_valid,
    output logic [CHW-1:0]         out_ch,
    output logic signed [OW-1:0]   p,
    output logic signed [ACCW-1:0] pcout,
    output logic                   out_sat
);

    localparam int PW = AW + 1 + BW;  // full product width

    if (ACCW < PW)                        begin : g_bad_accw  $error("ACCW must be >= AW+1+BW"); end
    if (NCH < 1)                          begin : g_bad_nch   $error("NCH must be >= 1");        end
    if (SHIFT < 0 || SHIFT > ACCW-1)      begin : g_bad_shift $error("SHIFT out of range");      end
    if (OW < 1 || OW > ACCW-SHIFT)        begin : g_bad_ow    $error("OW out of range");         end
    if (CHW > TAG_CHW)                    begin : g_bad_chw   $error("NCH too large for tag");   end

    // Stage registers
    stage_tag_t             tag1_q, tag2_q, tag3_q;
    logic signed [AW-1:0]   a1_q, d1_q;
    logic signed [BW-1:0]   b1_q, b2_q;
    logic signed [ACCW-1:0] c1_q, c2_q, c3_q;
    logic signed [AW:0]     ad2_q;
    logic signed [ACCW-1:0] m3_q;
    logic signed [ACCW-1:0] acc_q [NCH];

    logic                   out_valid_q, out_sat_q;
    logic [CHW-1:0]         out_ch_q;
    logic signed [OW-1:0]   p_q;
    logic signed [ACCW-1:0] pcout_q;

    // Next-state / combinational
    stage_tag_t             tag1_d;
    logic signed [AW:0]     ad2_d;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] m3_d, r_d, acc_rd;
    logic [TAG_CHW-1:0]     acc_idx;
    logic signed [OW-1:0]   p_d;
    logic                   sat_d;
    logic                   unused_tag;

    assign tag1_d = '{valid: in_valid, ch: TAG_CHW'(in_ch), op: in_op, first: in_first};

    // AW+1 bits cannot overflow for a sum/difference of two AW-bit values
    assign ad2_d = tag1_q.op[PRE_SUB] ? ({a1_q[AW-1], a1_q} - {d1_q[AW-1], d1_q})
                                      : ({a1_q[AW-1], a1_q} + {d1_q[AW-1], d1_q});
    assign prod  = PW'(b2_q) * PW'(ad2_q);
    assign m3_d  = ACCW'(prod);

    // Out-of-range channel tags fold onto the existing accumulators
    assign acc_idx    = tag3_q.ch % TAG_CHW'(NCH);
    assign unused_tag = tag3_q.op[PRE_SUB];

    always_comb begin
        acc_rd = '0;
        for (int k = 0; k < NCH; k++) begin
            if (acc_idx == TAG_CHW'(k)) acc_rd = acc_q[k];
        end
    end

    // Accumulator read and write both happen here, so same-channel
    // back-to-back samples see the prior result without forwarding.
    always_comb begin
        r_d = '0;
        case (tag3_q.op[1:0])
            OP_ADD_C: r_d = m3_q + c3_q;
            OP_C_SUB: r_d = c3_q - m3_q;
            OP_ACC:   r_d = (tag3_q.first ? '0 : acc_rd) + m3_q;
            OP_CASC:  r_d = pcin + m3_q;
        endcase
    end

    dsp_mac_outfmt #(.ACCW(ACCW), .SHIFT(SHIFT), .OW(OW)) u_outfmt (
        .r_i   (r_d),
        .p_o   (p_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag1_q      <= '0;
            tag2_q      <= '0;
            tag3_q      <= '0;
            a1_q        <= '0;
            d1_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            ad2_q       <= '0;
            m3_q        <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_ch_q    <= '0;
            p_q         <= '0;
            pcout_q     <= '0;
            for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
        end else if (ce) begin
            tag1_q      <= tag1_d;
            a1_q        <= a;
            d1_q        <= d;
            b1_q        <= b;
            c1_q        <= c;
            tag2_q      <= tag1_q;
            ad2_q       <= ad2_d;
            b2_q        <= b1_q;
            c2_q        <= c1_q;
            tag3_q      <= tag2_q;
            m3_q        <= m3_d;
            c3_q        <= c2_q;
            out_valid_q <= tag3_q.valid;
            if (tag3_q.valid) begin
                p_q       <= p_d;
                pcout_q   <= r_d;
                out_sat_q <= sat_d;
                out_ch_q  <= tag3_q.ch[CHW-1:0];
                if (tag3_q.op[1:0] == OP_ACC) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (acc_idx == TAG_CHW'(k)) acc_q[k] <= r_d;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign p         = p_q;
    assign pcout     = pcout_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a default instance (OW=48, SHIFT=0) and a
// formatter instance (OW=16, SHIFT=2) driven by the same inputs.
module tb_dsp_mac_pipe;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;
    logic in_valid = 1'b0;
    logic [1:0] in_ch = '0;
    logic [2:0] in_op = '0;
    logic in_first = 1'b0;
    logic signed [24:0] a = '0, d = '0;
    logic signed [17:0] b = '0;
    logic signed [47:0] c = '0, pcin = '0;

    logic out_valid, out_sat, out_valid_f, out_sat_f;
    logic [1:0] out_ch, out_ch_f;
    logic signed [47:0] p, pcout, pcout_f;
    logic signed [15:0] p_f;

    int total = 0;
    int bad = 0;
    logic signed [47:0] q_p[$];
    logic [1:0] q_ch[$];
    logic ce_s;

`ifdef DSP_MAC_SAT_EN
    localparam logic signed [15:0] EXP_POS = 16'h7FFF;
    localparam logic signed [15:0] EXP_NEG = 16'h8000;
    localparam logic EXP_SAT = 1'b1;
`else
    localparam logic signed [15:0] EXP_POS = 16'h9C40;  // -25536
    localparam logic signed [15:0] EXP_NEG = 16'h63C0;  // 25536
    localparam logic EXP_SAT = 1'b0;
`endif

    dsp_mac_pipe u_dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ch(in_ch),
        .in_op(in_op), .in_first(in_first), .a(a), .d(d), .b(b), .c(c), .pcin(pcin),
        .out_valid(out_valid), .out_ch(out_ch), .p(p), .pcout(pcout), .out_sat(out_sat)
    );

    dsp_mac_pipe #(.SHIFT(2), .OW(16)) u_fmt (
        .clock(clock), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ch(in_ch),
        .in_op(in_op), .in_first(in_first), .a(a), .d(d), .b(b), .c(c), .pcin(pcin),
        .out_valid(out_valid_f), .out_ch(out_ch_f), .p(p_f), .pcout(pcout_f), .out_sat(out_sat_f)
    );

    always #5 clock = ~clock;

    // Records one entry per output actually produced (edge with ce=1)
    always @(posedge clock) begin
        ce_s = ce;
        #1;
        if (ce_s && out_valid) begin
            q_p.push_back(p);
            q_ch.push_back(out_ch);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic send(input int av, input int dv, input int bv, input int cv,
                        input logic [2:0] op, input int ch, input logic first);
        a = 25'(av); d = 25'(dv); b = 18'(bv); c = 48'(cv);
        in_op = op; in_ch = 2'(ch); in_first = first; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (p !== 48'sd0) begin bad++; $display("FAIL reset_p: got %0d want 0", p); end
        total++; if (pcout !== 48'sd0) begin bad++; $display("FAIL reset_pcout: got %0d want 0", pcout); end
        total++; if (out_ch !== 2'd0 || out_sat !== 1'b0) begin bad++; $display("FAIL reset_ch_sat: got %0d/%0b want 0/0", out_ch, out_sat); end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic();
        send(3, 2, 4, 10, 3'b000, 0, 1'b0);
        step(2);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %0b want 0", out_valid); end
        step(1);
        total++; if (out_valid !== 1'b1 || p !== 48'sd30 || pcout !== 48'sd30)
            begin bad++; $display("FAIL basic: got v=%0b p=%0d pcout=%0d want 1/30/30", out_valid, p, pcout); end
        step(1);
        total++; if (out_valid !== 1'b0 || p !== 48'sd30)
            begin bad++; $display("FAIL basic_hold: got v=%0b p=%0d want 0/30", out_valid, p); end
    endtask

    task automatic test_presub();
        send(3, 5, 7, 100, 3'b101, 2, 1'b0);
        step(3);
        total++; if (out_valid !== 1'b1 || p !== 48'sd114 || out_ch !== 2'd2)
            begin bad++; $display("FAIL presub: got v=%0b p=%0d ch=%0d want 1/114/2", out_valid, p, out_ch); end
    endtask

    task automatic test_cascade();
        pcin = -48'sd7;
        send(2, 1, 5, 999, 3'b011, 3, 1'b0);  // m = 15
        step(2);
        pcin = 48'sd1000;                     // only the S4 value may count
        step(1);
        total++; if (p !== 48'sd1015 || pcout !== 48'sd1015)
            begin bad++; $display("FAIL cascade: got p=%0d pcout=%0d want 1015", p, pcout); end
        pcin = '0;
    endtask

    task automatic test_interleave();
        logic signed [47:0] ep [9] = '{5, 1, 11, 2, 18, 0, 0, 4, 6};
        logic [1:0]         ec [9] = '{1, 0, 1, 0, 1, 2, 3, 0, 0};
        q_p.delete(); q_ch.delete();
        send(5, 0, 1, 0, 3'b010, 1, 1'b1);
        send(1, 0, 1, 0, 3'b010, 0, 1'b1);
        send(6, 0, 1, 0, 3'b010, 1, 1'b0);
        send(1, 0, 1, 0, 3'b010, 0, 1'b0);
        send(7, 0, 1, 0, 3'b010, 1, 1'b0);
        send(0, 0, 1, 0, 3'b010, 2, 1'b0);  // acc[2] still 0
        send(0, 0, 1, 0, 3'b010, 3, 1'b0);  // acc[3] still 0
        send(2, 0, 1, 0, 3'b010, 0, 1'b0);  // same channel back to back
        send(2, 0, 1, 0, 3'b010, 0, 1'b0);
        step(5);
        total++; if (q_p.size() != 9) begin bad++; $display("FAIL interleave_count: got %0d want 9", q_p.size()); end
        for (int i = 0; i < 9 && i < q_p.size(); i++) begin
            total++; if (q_p[i] !== ep[i] || q_ch[i] !== ec[i])
                begin bad++; $display("FAIL interleave[%0d]: got p=%0d ch=%0d want %0d/%0d", i, q_p[i], q_ch[i], ep[i], ec[i]); end
        end
    endtask

    task automatic test_stall_bubble();
        logic signed [47:0] ep [4] = '{3, 7, 7, 12};
        logic [1:0]         ec [4] = '{0, 3, 0, 0};
        q_p.delete(); q_ch.delete();
        send(3, 0, 1, 0, 3'b010, 0, 1'b1);
        send(1, 0, 2, 5, 3'b000, 3, 1'b0);
        step(2);
        total++; if (out_valid !== 1'b1 || p !== 48'sd3) begin bad++; $display("FAIL stall_pre: got v=%0b p=%0d want 1/3", out_valid, p); end
        ce = 1'b0;
        a = 25'sd100; b = 18'sd1; d = '0; in_op = 3'b010; in_ch = 2'd0; in_first = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++; if (out_valid !== 1'b1 || p !== 48'sd3)
                begin bad++; $display("FAIL stall_hold[%0d]: got v=%0b p=%0d want 1/3", i, out_valid, p); end
        end
        ce = 1'b1; in_valid = 1'b0;
        send(4, 0, 1, 0, 3'b010, 0, 1'b0);
        step(1);
        send(5, 0, 1, 0, 3'b010, 0, 1'b0);
        step(5);
        total++; if (q_p.size() != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", q_p.size()); end
        for (int i = 0; i < 4 && i < q_p.size(); i++) begin
            total++; if (q_p[i] !== ep[i] || q_ch[i] !== ec[i])
                begin bad++; $display("FAIL stall[%0d]: got p=%0d ch=%0d want %0d/%0d", i, q_p[i], q_ch[i], ep[i], ec[i]); end
        end
    endtask

    task automatic test_format();
        send(400, 0, 400, 0, 3'b000, 0, 1'b0);  // r = 160000
        step(3);
        total++; if (p !== 48'sd160000 || out_sat !== 1'b0) begin bad++; $display("FAIL fmt_wide: got p=%0d sat=%0b want 160000/0", p, out_sat); end
        total++; if (p_f !== EXP_POS || out_sat_f !== EXP_SAT)
            begin bad++; $display("FAIL fmt_pos: got p=%0d sat=%0b want %0d/%0b", p_f, out_sat_f, EXP_POS, EXP_SAT); end
        total++; if (pcout_f !== 48'sd160000) begin bad++; $display("FAIL fmt_pcout: got %0d want 160000", pcout_f); end
        send(-400, 0, 400, 0, 3'b000, 0, 1'b0);  // r = -160000
        step(3);
        total++; if (p_f !== EXP_NEG || out_sat_f !== EXP_SAT)
            begin bad++; $display("FAIL fmt_neg: got p=%0d sat=%0b want %0d/%0b", p_f, out_sat_f, EXP_NEG, EXP_SAT); end
        send(-2, 0, 4, 0, 3'b000, 0, 1'b0);  // r = -8
        step(3);
        total++; if (p_f !== -16'sd2 || out_sat_f !== 1'b0)
            begin bad++; $display("FAIL fmt_small: got p=%0d sat=%0b want -2/0", p_f, out_sat_f); end
    endtask

    task automatic test_reset_midflight();
        send(100, 0, 1, 0, 3'b010, 1, 1'b0);
        send(100, 0, 1, 0, 3'b010, 1, 1'b0);
        send(100, 0, 1, 0, 3'b010, 1, 1'b0);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_flush[%0d]: got v=%0b want 0", i, out_valid); end
            step(1);
        end
        send(4, 0, 1, 0, 3'b010, 1, 1'b0);
        step(3);
        total++; if (out_valid !== 1'b1 || p !== 48'sd4 || out_ch !== 2'd1)
            begin bad++; $display("FAIL rst_acc: got v=%0b p=%0d ch=%0d want 1/4/1", out_valid, p, out_ch); end
    endtask

    initial begin
        step(2);
        test_reset();
        test_basic();
        test_presub();
        test_cascade();
        test_interleave();
        test_stall_bubble();
        test_format();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
